shifter_seq: RTL and testbench
==============================

// Module: shifter_seq
// PURPOSE
//  Multi-cycle iterative shifter with valid/ready handshakes on both sides; shifts one
//  bit position per clock. Issues the same four ops as the combinational barrel shifter,
//  trading area for latency.
//  An upstream issuer presents {in_data,in_cnt,in_op}; a downstream consumer takes out_data.
// PARAMETERS
//  N  16  data width (bits)
//  C  4   shift-count width; N == 2**C
//  O  2   op-code width
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  request {in_data,in_cnt,in_op} is valid
//  in_ready   out  1  block can accept a request this cycle
//  in_data    in   N  operand
//  in_cnt     in   C  shift amount, 0..N-1
//  in_op      in   O  00 rotate-left, 01 shift-left logical, 10 shift-right arith, 11 shift-right logical
//  out_valid  out  1  out_data holds a completed result
//  out_ready  in   1  consumer takes result this cycle
//  out_data   out  N  result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n=0, 1 in first cycle after release;
//   out_valid=0; out_data=0; count register=0. Reset at any point aborts any in-flight op;
//   no result is produced for it.
//  States:
//   IDLE  : in_ready=1, out_valid=0. On in_valid: latch data/cnt/op.
//           cnt==0 -> DONE, cnt!=0 -> SHIFT with rem=cnt.
//   SHIFT : in_ready=0. Each edge: data shifted by exactly 1 per op, rem<=rem-1.
//           Edge where rem==1 -> DONE.
//   DONE  : out_valid=1, out_data stable. On out_ready -> IDLE; else hold DONE, data, valid.
//  Per-step op (1-bit): ROL d={d[N-2:0],d[N-1]}; SLL d={d[N-2:0],1'b0};
//   SRA d={d[N-1],d[N-1:1]}; SRL d={1'b0,d[N-1:1]}.
//  Latency: out_valid rises max(in_cnt,1) cycles after the accept edge.
//   cnt=0 -> 1 cycle, result = in_data unchanged. cnt=15 -> 15 cycles.
//  Throughput: one op in flight. Accept in IDLE only; next accept is earliest 1 cycle after
//   the out handshake edge. No bypass from DONE to the next request.
//  in_* ignored whenever in_ready=0; changing them mid-op has no effect.
//  out_ready ignored when out_valid=0.
//  out_data holds last result after handshake until the next DONE; reads 0 only after reset.
//  Simultaneous in_valid and out_ready in DONE: out handshake completes, request not accepted.
//  in_op latched at accept; the op cannot change mid-shift.
// TESTING
//  ROL in_data=16'h8001 cnt=1 -> out_data=16'h0003, out_valid 1 cycle after accept.
//  SRA in_data=16'h8000 cnt=15 -> 16'hFFFF, out_valid exactly 15 cycles after accept,
//   in_ready=0 throughout.
//  SLL in_data=16'h1234 cnt=0 -> 16'h1234 after 1 cycle.
//   SRL 16'h1234 cnt=0 -> 16'h1234.
//  SRL in_data=16'hA0A0 cnt=4, out_ready held 0 for 3 cycles in DONE -> out_data=16'h0A0A
//   stable and out_valid=1 all 3 cycles. in_ready=1 the cycle after out_ready=1.
//  Reset mid-op: SLL 16'hFFFF cnt=8, drop rst_n after 3 shift cycles -> out_valid=0,
//   out_data=0 immediately. After release in_ready=1 and no stale result.
//  Random: 2000 back-to-back ops (random data/cnt/op, random out_ready stalls) vs golden
//   model -> zero mismatches; latency == max(cnt,1) every op.

Source files
------------

// File: rtl/shifter_seq.sv
// shifter_seq: iterative shifter that moves one bit position per clock.
// Four ops (rotate-left, shift-left logical, shift-right arithmetic,
// shift-right logical) share one 1-bit step datapath, so an op takes
// max(cnt,1) cycles from accept to result.
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid and ready are both high. The producer must hold its payload
// stable while valid is high and ready is low; ready never depends on valid.
// Here in_ready is high only in IDLE, and out_valid only in DONE, so a
// request can never be accepted on the same edge a result is taken.
module shifter_seq #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [C-1:0] in_cnt,
  input  logic [O-1:0] in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  localparam logic [O-1:0] OP_ROL = 0;
  localparam logic [O-1:0] OP_SLL = 1;
  localparam logic [O-1:0] OP_SRA = 2;
  localparam logic [O-1:0] OP_SRL = 3;
  localparam logic [C-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] work;     // operand being shifted in place
  logic [C-1:0] rem;      // remaining step count, 1..N-1 while in SHIFT
  logic [O-1:0] op;       // op captured at accept, fixed for the whole op
  logic         hold;     // zero-count request: spend one cycle without shifting
  logic [N-1:0] stepped;  // work after one step of the captured op

  // One-bit step of the selected op.
  function automatic logic [N-1:0] step1(input logic [N-1:0] d, input logic [O-1:0] o);
    logic [N-1:0] r;
    r = d;
    case (o)
      OP_ROL:  r = {d[N-2:0], d[N-1]};
      OP_SLL:  r = {d[N-2:0], 1'b0};
      OP_SRA:  r = {d[N-1], d[N-1:1]};
      OP_SRL:  r = {1'b0, d[N-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Next value of the working register for the current SHIFT cycle.
  always_comb begin
    stepped = work;
    if (!hold) begin
      stepped = step1(work, op);
    end
  end

  // Control FSM with registered handshake outputs and datapath registers.
  // A zero-count request still passes through one SHIFT cycle (with the
  // step masked) so every op obeys latency = max(cnt,1).
  // in_ready resets low and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      work      <= '0;
      rem       <= '0;
      op        <= '0;
      hold      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            work     <= in_data;
            op       <= in_op;
            hold     <= (in_cnt == '0);
            rem      <= (in_cnt == '0) ? CNT_ONE : in_cnt;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          in_ready <= 1'b0;
          work     <= stepped;
          rem      <= rem - CNT_ONE;
          if (rem == CNT_ONE) begin
            out_data  <= stepped;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Result and valid hold until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: scoreboard bench for shifter_seq. The driver pushes the
// expected result and latency when a request is issued; a monitor pops and
// compares whenever a new result appears on the output side.
module tb_shifter_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  shifter_seq #(.N(16), .C(4), .O(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];

  bit          busy = 0;
  bit          shown = 0;
  int          busy_cnt = 0;
  logic [15:0] held = '0;
  bit          rand_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference model: whole shift computed arithmetically in one go.
  function automatic logic [15:0] model(input logic [15:0] d, input int c, input logic [1:0] o);
    logic [31:0] x;
    logic [31:0] sx;
    logic [31:0] r;
    x  = {16'h0000, d};
    sx = {{16{d[15]}}, d};
    case (o)
      2'd0:    r = (x << c) | (x >> (16 - c));
      2'd1:    r = x << c;
      2'd2:    r = sx >> c;
      default: r = x >> c;
    endcase
    return r[15:0];
  endfunction

  // Edge bookkeeping: accept time, output handshake, stuck-op watchdog.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc);
        busy     = 1;
        busy_cnt = 0;
      end
      if (out_valid && out_ready) begin
        shown = 0;
        busy  = 0;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_cnt > 60) begin
          fail_now("watchdog");
          busy = 0;
        end
      end
    end
  end

  // Random consumer back-pressure.
  always @(negedge clk) begin
    if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare each new result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (!shown) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_out", {31'd0, out_valid}, 32'd0);
          end else begin
            logic [15:0] e;
            int          l;
            int          a;
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            a = acc_q.pop_front();
            chk("result", {16'h0, out_data}, {16'h0, e});
            chk("latency", cyc - a, l);
          end
          held  = out_data;
          shown = 1;
        end else begin
          chk("hold_data", {16'h0, out_data}, {16'h0, held});
        end
        chk("ready_in_done", {31'd0, in_ready}, 32'd0);
      end else if (busy) begin
        chk("ready_busy", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  // Driver: present a request at a negedge and hold it until accepted.
  task automatic do_op(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                       input bit use_exp, input logic [15:0] ev);
    int waited = 0;
    in_data  = d;
    in_cnt   = c;
    in_op    = o;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(use_exp ? ev : model(d, int'(c), o));
    lat_q.push_back((c == 4'd0) ? 1 : int'(c));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_cnt   = 4'($urandom);
    in_op    = 2'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (busy || exp_q.size() != 0) fail_now("drain");
  endtask

  task automatic clear_sb();
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    busy  = 0;
    shown = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cnt    = '0;
    in_op     = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // directed cases with hand-derived results
    do_op(16'h8001, 4'd1, 2'd0, 1, 16'h0003);
    do_op(16'h8000, 4'd15, 2'd2, 1, 16'hFFFF);
    do_op(16'h1234, 4'd0, 2'd1, 1, 16'h1234);
    do_op(16'h1234, 4'd0, 2'd3, 1, 16'h1234);
    wait_idle(100);

    // consumer stall in DONE
    out_ready = 1'b0;
    do_op(16'hA0A0, 4'd4, 2'd3, 1, 16'h0A0A);
    begin
      int k = 0;
      while (!out_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!out_valid) fail_now("stall_valid");
    end
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
    chk("valid_after_hs", {31'd0, out_valid}, 32'd0);
    chk("data_after_hs", {16'h0, out_data}, 32'h0A0A);
    @(negedge clk);

    // reset in the middle of a shift
    do_op(16'hFFFF, 4'd8, 2'd1, 1, 16'hFF00);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    clear_sb();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {16'h0, out_data}, 32'h0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("no_stale_valid", {31'd0, out_valid}, 32'd0);

    // random back-to-back traffic with consumer stalls
    rand_stall = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) @(negedge clk);
      do_op(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 0, 16'h0);
    end
    wait_idle(1000);
    rand_stall = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
